// File: rtl/scan_link_arbiter.sv
// Round-robin arbiter that gives one of two scanners the outbound link and pops
// words out of that scanner's buffer while the link accepts them.
module scan_link_arbiter #(
  parameter int unsigned CW         = 4,
  parameter int unsigned MAX_WORDS  = 10,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    i_req,
  input  logic [CW-1:0] i_buf_count_1,
  input  logic [CW-1:0] i_buf_count_2,
  input  logic          i_link_ready,
  output logic [1:0]    o_grant,
  output logic [1:0]    o_pop,
  output logic          o_xfer_active,
  output logic          o_xfer_done,
  output logic          o_xfer_abort,
  output logic [CW-1:0] o_words_left,
  output logic [CW-1:0] o_words_sent
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] MaxWords = CW'(MAX_WORDS);
  localparam logic [GW-1:0] GapLast  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StGap} state_e;

  state_e        r_state, w_state_next;
  logic          r_sel, w_sel_next;      // 0 = scanner 1, 1 = scanner 2
  logic          r_last, w_last_next;
  logic [1:0]    r_grant, w_grant_next;
  logic          r_active, w_active_next;
  logic          r_done, w_done_next;
  logic          r_abort, w_abort_next;
  logic [CW-1:0] r_words_left, w_words_left_next;
  logic [CW-1:0] r_words_sent, w_words_sent_next;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_next;

  logic [1:0]    w_elig;
  logic          w_pick;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_len;
  logic          w_req_sel;
  logic          w_pop_en;
  state_e        w_end_state;

  assign w_elig      = {i_req[1] && (i_buf_count_2 != '0), i_req[0] && (i_buf_count_1 != '0)};
  // On a tie the scanner that was not served last wins.
  assign w_pick      = (&w_elig) ? ~r_last : w_elig[1];
  assign w_count     = w_pick ? i_buf_count_2 : i_buf_count_1;
  assign w_len       = (w_count > MaxWords) ? MaxWords : w_count;
  assign w_req_sel   = r_sel ? i_req[1] : i_req[0];
  assign w_pop_en    = (r_state == StXfer) && w_req_sel && i_link_ready;
  assign w_end_state = (GAP_CYCLES == 0) ? StIdle : StGap;

  assign o_pop         = w_pop_en ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign o_grant       = r_grant;
  assign o_xfer_active = r_active;
  assign o_xfer_done   = r_done;
  assign o_xfer_abort  = r_abort;
  assign o_words_left  = r_words_left;
  assign o_words_sent  = r_words_sent;

  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_last_next       = r_last;
    w_grant_next      = r_grant;
    w_active_next     = r_active;
    w_done_next       = 1'b0;
    w_abort_next      = 1'b0;
    w_words_left_next = r_words_left;
    w_words_sent_next = r_words_sent;
    w_gap_cnt_next    = r_gap_cnt;
    case (r_state)
      StIdle: begin
        if (|w_elig) begin
          w_state_next      = StGrant;
          w_sel_next        = w_pick;
          w_last_next       = w_pick;
          w_grant_next      = w_pick ? 2'b10 : 2'b01;
          w_active_next     = 1'b1;
          w_words_left_next = w_len;
          w_words_sent_next = '0;
        end
      end
      StGrant: begin
        if (!w_req_sel) begin
          w_state_next   = w_end_state;
          w_grant_next   = 2'b00;
          w_active_next  = 1'b0;
          w_abort_next   = 1'b1;
          w_gap_cnt_next = '0;
        end else begin
          w_state_next = StXfer;
        end
      end
      StXfer: begin
        if (!w_req_sel) begin
          w_state_next   = w_end_state;
          w_grant_next   = 2'b00;
          w_active_next  = 1'b0;
          w_abort_next   = 1'b1;
          w_gap_cnt_next = '0;
        end else if (i_link_ready) begin
          w_words_left_next = r_words_left - CW'(1);
          w_words_sent_next = r_words_sent + CW'(1);
          if (r_words_left == CW'(1)) begin
            w_state_next   = w_end_state;
            w_grant_next   = 2'b00;
            w_active_next  = 1'b0;
            w_done_next    = 1'b1;
            w_gap_cnt_next = '0;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == GapLast) begin
          w_state_next = StIdle;
        end else begin
          w_gap_cnt_next = r_gap_cnt + GW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_grant      <= 2'b00;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_words_left <= '0;
      r_words_sent <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_last       <= w_last_next;
      r_grant      <= w_grant_next;
      r_active     <= w_active_next;
      r_done       <= w_done_next;
      r_abort      <= w_abort_next;
      r_words_left <= w_words_left_next;
      r_words_sent <= w_words_sent_next;
      r_gap_cnt    <= w_gap_cnt_next;
    end
  end

endmodule
